// File: rtl/stack_seq_pkg.sv
// Shared definitions for the data-stack sequencer: op-codes and FSM state encoding.
package stack_seq_pkg;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PEEK = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

endpackage

// File: rtl/stack_sequencer.sv
// Data-stack sequencer: owns SP, runs PUSH/POP/PEEK over one memory port,
// enforces stack bounds and returns popped words.
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter int unsigned         ADDR_W      = 16,
    parameter int unsigned         DATA_W      = 16,
    parameter logic [ADDR_W-1:0]   STACK_BASE  = 16'h0100,
    parameter logic [ADDR_W-1:0]   STACK_LIMIT = 16'h00FC
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [ADDR_W-1:0] sp,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_sp;
    logic                r_is_pop;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_pop_data;
    logic                r_pop_valid;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_accept;
    logic                w_full;
    logic                w_empty;
    logic                w_ack;
    logic                w_push_go;
    logic                w_rd_go;
    logic                w_ovf_set;
    logic                w_unf_set;

    assign w_accept = op_valid && (r_state == S_IDLE);
    assign w_full   = (r_sp == STACK_LIMIT);
    assign w_empty  = (r_sp == STACK_BASE);
    // An ack is only meaningful while a request is actually outstanding.
    assign w_ack    = mem_ack && r_mem_req;

    always_comb begin
        w_state_nxt = r_state;
        w_push_go   = 1'b0;
        w_rd_go     = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (op_code)
                        OP_PUSH: begin
                            if (w_full) begin
                                w_ovf_set = 1'b1;
                            end else begin
                                w_push_go   = 1'b1;
                                w_state_nxt = S_WR;
                            end
                        end
                        OP_POP, OP_PEEK: begin
                            if (w_empty) begin
                                w_unf_set = 1'b1;
                            end else begin
                                w_rd_go     = 1'b1;
                                w_state_nxt = S_RD;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_WR, S_RD: begin
                if (w_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_sp        <= STACK_BASE;
            r_is_pop    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pop_valid <= 1'b0;
            // Request signals are loaded at accept so they are stable from the first access cycle.
            if (w_push_go) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_sp - ADDR_W'(1);
                r_mem_wdata <= push_data;
            end
            if (w_rd_go) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= r_sp;
                r_is_pop   <= (op_code == OP_POP);
            end
            if (w_unf_set) begin
                r_pop_data  <= '0;
                r_pop_valid <= 1'b1;
            end
            if (w_ack) begin
                r_mem_req <= 1'b0;
                if (r_state == S_WR) begin
                    r_sp <= r_sp - ADDR_W'(1);
                end else begin
                    r_pop_data  <= mem_rdata;
                    r_pop_valid <= 1'b1;
                    if (r_is_pop) r_sp <= r_sp + ADDR_W'(1);
                end
            end
            r_overflow  <= (r_overflow  && !err_clr) || w_ovf_set;
            r_underflow <= (r_underflow && !err_clr) || w_unf_set;
        end
    end

    assign op_ready  = (r_state == S_IDLE);
    assign pop_data  = r_pop_data;
    assign pop_valid = r_pop_valid;
    assign sp        = r_sp;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
